mfp_ahb_interconnect: RTL and testbench

MFP_AHB_INTERCONNECT -- requirements
Module: mfp_ahb_interconnect

---
 rtl/mfp_ahb_pkg.sv | 35 +++
 rtl/mfp_ahb_addr_dec.sv | 36 +++
 rtl/mfp_ahb_interconnect.sv | 164 ++++++++++++++++
 tb/tb_mfp_ahb_interconnect.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_pkg.sv
// Shared encodings for the MFP AHB-Lite interconnect: transfer types,
// response codes, FSM states and error-cause codes.
package mfp_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SLV  = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_DECODE  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Only NONSEQ and SEQ carry a data phase; IDLE and BUSY complete at once.
    function automatic logic htrans_active(input logic [1:0] trans);
        logic active;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/mfp_ahb_addr_dec.sv
// Address decoder: masked compare per slave, lowest index wins, so the hit
// vector is at most one-hot. Purely combinational from the address.
module mfp_ahb_addr_dec
    import mfp_ahb_pkg::*;
#(
    parameter int                  N_SLV    = 5,
    parameter logic [32*N_SLV-1:0] SLV_BASE = {N_SLV{32'h0}},
    parameter logic [32*N_SLV-1:0] SLV_MASK = {N_SLV{32'h0}}
) (
    input  logic [31:0]      addr,
    input  logic             write,
    output logic [N_SLV-1:0] hit,
    output logic             miss
);

    logic found;

    // Direction plays no part in routing; it is accepted here only so the
    // decoder sees the full address-phase request.
    logic unused_write;
    assign unused_write = write;

    // Priority decode: first matching slave claims the address.
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!found && ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = !found;
    end

endmodule

// File: rtl/mfp_ahb_interconnect.sv
// Single-master AHB-Lite interconnect: address decode, registered data-phase
// select, response mux, default-slave error responses and a stall timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no data phase in progress; bus ready with OKAY
//   SLV     | data phase owned by a decoded slave; its response passes through
//   ERR1    | first cycle of an interconnect ERROR (decode miss or timeout)
//   ERR2    | second cycle of that ERROR; next address phase is taken here
module mfp_ahb_interconnect
    import mfp_ahb_pkg::*;
#(
    parameter int                  N_SLV    = 5,
    parameter logic [32*N_SLV-1:0] SLV_BASE = {N_SLV{32'h0}},
    parameter logic [32*N_SLV-1:0] SLV_MASK = {N_SLV{32'h0}},
    parameter int                  TIMEOUT  = 256
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    output logic [31:0]        HRDATA,
    output logic               HREADY,
    output logic               HRESP,
    output logic [N_SLV-1:0]   HSEL_S,
    input  logic [32*N_SLV-1:0] HRDATA_S,
    input  logic [N_SLV-1:0]   HREADYOUT_S,
    input  logic [N_SLV-1:0]   HRESP_S,
    output logic               ERR_IRQ,
    output logic [1:0]         ERR_CAUSE
);

    localparam int             CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT - 1);

    state_t           state;
    logic [N_SLV:0]   dsel;      // bit N_SLV is the default (error) slave
    logic [CW-1:0]    cnt;
    logic             err_irq;
    logic [1:0]       err_cause;

    logic [N_SLV-1:0] dec_hit;
    logic             dec_miss;
    logic             sel_ready;
    logic             sel_resp;
    logic [31:0]      sel_rdata;
    logic             hready_int;
    logic             hresp_int;
    logic [31:0]      hrdata_int;
    logic             accept;
    logic             timeout_hit;

    mfp_ahb_addr_dec #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_dec (
        .addr  (HADDR),
        .write (HWRITE),
        .hit   (dec_hit),
        .miss  (dec_miss)
    );

    assign HSEL_S = dec_hit;

    // The default-slave bit is kept for visibility; error-state outputs come
    // straight from the FSM state.
    logic unused_dflt;
    assign unused_dflt = dsel[N_SLV];

    // Response mux from the slave that owns the current data phase.
    always_comb begin
        sel_ready = 1'b1;
        sel_resp  = HRESP_OKAY;
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (dsel[i]) begin
                sel_ready = HREADYOUT_S[i];
                sel_resp  = HRESP_S[i];
                sel_rdata = HRDATA_S[32*i +: 32];
            end
        end
    end

    // Bus-side response per state; slave responses pass with zero latency.
    always_comb begin
        hready_int = 1'b1;
        hresp_int  = HRESP_OKAY;
        hrdata_int = '0;
        case (state)
            ST_IDLE: begin
                hready_int = 1'b1;
                hresp_int  = HRESP_OKAY;
            end
            ST_SLV: begin
                hready_int = sel_ready;
                hresp_int  = sel_resp;
                hrdata_int = sel_rdata;
            end
            ST_ERR1: begin
                hready_int = 1'b0;
                hresp_int  = HRESP_ERROR;
            end
            ST_ERR2: begin
                hready_int = 1'b1;
                hresp_int  = HRESP_ERROR;
            end
        endcase
    end

    // Hold the bus in a clean ready/OKAY condition for the whole reset cycle,
    // not just after the reset edge.
    assign HREADY    = HRESET ? 1'b1       : hready_int;
    assign HRESP     = HRESET ? HRESP_OKAY : hresp_int;
    assign HRDATA    = HRESET ? 32'h0      : hrdata_int;
    assign ERR_IRQ   = err_irq;
    assign ERR_CAUSE = err_cause;

    assign accept      = hready_int && htrans_active(HTRANS);
    assign timeout_hit = (state == ST_SLV) && !sel_ready && (cnt == TMAX);

    // Transfer sequencing, data-phase select, wait counter and error reporting.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            dsel      <= '0;
            cnt       <= '0;
            err_irq   <= 1'b0;
            err_cause <= CAUSE_NONE;
        end else begin
            err_irq <= 1'b0;
            if (state == ST_ERR1) begin
                state <= ST_ERR2;
            end else if (timeout_hit) begin
                // Abandon the stalled slave; its later responses are not muxed.
                state     <= ST_ERR1;
                dsel      <= {1'b1, {N_SLV{1'b0}}};
                cnt       <= '0;
                err_irq   <= 1'b1;
                err_cause <= CAUSE_TIMEOUT;
            end else if (hready_int) begin
                cnt <= '0;
                if (accept) begin
                    if (dec_miss) begin
                        state     <= ST_ERR1;
                        dsel      <= {1'b1, {N_SLV{1'b0}}};
                        err_irq   <= 1'b1;
                        err_cause <= CAUSE_DECODE;
                    end else begin
                        state <= ST_SLV;
                        dsel  <= {1'b0, dec_hit};
                    end
                end else begin
                    state <= ST_IDLE;
                    dsel  <= '0;
                end
            end else if (state == ST_SLV) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// Self-checking bench for mfp_ahb_interconnect with two slaves and an
// 8-cycle timeout. Completed data phases are checked against a queue of
// expected responses pushed when each address phase is driven.
module tb_mfp_ahb_interconnect;
    import mfp_ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [1:0]  HSEL_S;
    logic [63:0] hrdata_s;
    logic [1:0]  hreadyout_s;
    logic [1:0]  hresp_s;
    logic        ERR_IRQ;
    logic [1:0]  ERR_CAUSE;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic dp_active = 1'b0;

    mfp_ahb_interconnect #(
        .N_SLV    (2),
        .SLV_BASE ({32'h0000_0000, 32'h1FC0_0000}),
        .SLV_MASK ({32'h1000_0000, 32'h1FC0_0000}),
        .TIMEOUT  (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HSEL_S      (HSEL_S),
        .HRDATA_S    (hrdata_s),
        .HREADYOUT_S (hreadyout_s),
        .HRESP_S     (hresp_s),
        .ERR_IRQ     (ERR_IRQ),
        .ERR_CAUSE   (ERR_CAUSE)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic resp);
        exp_t e;
        e.rdata = rdata;
        e.resp  = resp;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    // Scoreboard: a data phase completes on the first HREADY=1 after acceptance.
    always @(negedge HCLK) begin
        exp_t e;
        if (HRESET) begin
            dp_active = 1'b0;
            sb_q.delete();
        end else if (HREADY) begin
            if (dp_active) begin
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("sb_hrdata", HRDATA, e.rdata);
                    chk("sb_hresp", 32'(HRESP), 32'(e.resp));
                end
            end
            dp_active = htrans_active(HTRANS);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        HRESET      = 1'b1;
        HADDR       = 32'h0;
        HTRANS      = HTRANS_IDLE;
        HWRITE      = 1'b0;
        hrdata_s    = 64'h0;
        hreadyout_s = 2'b11;
        hresp_s     = 2'b00;

        // Reset state
        cyc(); cyc();
        smp();
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp",  32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_irq",    32'(ERR_IRQ), 32'd0);
        chk("rst_cause",  32'(ERR_CAUSE), 32'd0);
        cyc(); HRESET = 1'b0;

        // Zero-wait read from slave0
        cyc();
        HADDR = 32'h1FC0_0010; HTRANS = HTRANS_NONSEQ;
        hrdata_s[31:0] = 32'hCAFE_F00D;
        push_exp(32'hCAFE_F00D, 1'b0);
        smp();
        chk("rd_hsel",   32'(HSEL_S), 32'd1);
        chk("rd_hready", 32'(HREADY), 32'd1);
        cyc(); HTRANS = HTRANS_IDLE; HADDR = 32'h0;
        smp();
        chk("rd_hrdata", HRDATA, 32'hCAFE_F00D);
        chk("rd_irq",    32'(ERR_IRQ), 32'd0);

        // Slave1 with 3 wait states, next address held across the stall
        cyc();
        HADDR = 32'h0000_1000; HTRANS = HTRANS_NONSEQ;
        hrdata_s[63:32] = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0);
        smp();
        chk("ws_hsel", 32'(HSEL_S), 32'd2);
        cyc();
        HADDR = 32'h1FC0_0020; HTRANS = HTRANS_NONSEQ;
        hreadyout_s[1] = 1'b0;
        hrdata_s[31:0] = 32'hA5A5_0001;
        push_exp(32'hA5A5_0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            smp();
            chk($sformatf("ws_stall%0d", i), 32'(HREADY), 32'd0);
        end
        cyc(); hreadyout_s[1] = 1'b1;
        smp();
        chk("ws_release_hready", 32'(HREADY), 32'd1);
        chk("ws_release_hrdata", HRDATA, 32'h1234_5678);
        cyc(); HTRANS = HTRANS_IDLE; HADDR = 32'h0;
        smp();
        chk("ws_b2b_hready", 32'(HREADY), 32'd1);
        chk("ws_b2b_hrdata", HRDATA, 32'hA5A5_0001);

        // Decode error
        cyc();
        HADDR = 32'h1000_0000; HTRANS = HTRANS_NONSEQ;
        push_exp(32'h0, 1'b1);
        smp();
        chk("de_hsel", 32'(HSEL_S), 32'd0);
        cyc(); HTRANS = HTRANS_IDLE;
        smp();
        chk("de1_hready", 32'(HREADY), 32'd0);
        chk("de1_hresp",  32'(HRESP), 32'd1);
        chk("de1_irq",    32'(ERR_IRQ), 32'd1);
        chk("de1_cause",  32'(ERR_CAUSE), 32'd1);
        chk("de1_hrdata", HRDATA, 32'h0);
        cyc(); smp();
        chk("de2_hready", 32'(HREADY), 32'd1);
        chk("de2_hresp",  32'(HRESP), 32'd1);
        chk("de2_irq",    32'(ERR_IRQ), 32'd0);
        cyc(); smp();
        chk("de_idle_hready", 32'(HREADY), 32'd1);
        chk("de_idle_hresp",  32'(HRESP), 32'd0);
        cyc(); smp();
        chk("de_idle_irq",   32'(ERR_IRQ), 32'd0);
        chk("de_idle_cause", 32'(ERR_CAUSE), 32'd1);

        // Timeout: slave0 never ready, then a late ready during ERR1
        cyc();
        HADDR = 32'h1FC0_0040; HTRANS = HTRANS_NONSEQ;
        hrdata_s[31:0] = 32'hDEAD_BEEF;
        push_exp(32'h0, 1'b1);
        smp();
        cyc(); HTRANS = HTRANS_IDLE; HADDR = 32'h0; hreadyout_s[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            smp();
            chk($sformatf("to_wait%0d", i), 32'(HREADY), 32'd0);
            chk($sformatf("to_wait_irq%0d", i), 32'(ERR_IRQ), 32'd0);
        end
        cyc(); hreadyout_s[0] = 1'b1;
        smp();
        chk("to_err1_hready", 32'(HREADY), 32'd0);
        chk("to_err1_hresp",  32'(HRESP), 32'd1);
        chk("to_err1_irq",    32'(ERR_IRQ), 32'd1);
        chk("to_err1_cause",  32'(ERR_CAUSE), 32'd2);
        chk("to_err1_hrdata", HRDATA, 32'h0);
        cyc(); smp();
        chk("to_err2_hready", 32'(HREADY), 32'd1);
        chk("to_err2_hresp",  32'(HRESP), 32'd1);
        chk("to_err2_hrdata", HRDATA, 32'h0);
        cyc(); smp();
        chk("to_idle_hresp", 32'(HRESP), 32'd0);
        chk("to_idle_cause", 32'(ERR_CAUSE), 32'd2);

        // Slave-generated two-cycle ERROR passes through without an interrupt
        cyc();
        HADDR = 32'h0000_2000; HTRANS = HTRANS_NONSEQ;
        hrdata_s[63:32] = 32'h5A5A_0000;
        push_exp(32'h5A5A_0000, 1'b1);
        smp();
        cyc(); HTRANS = HTRANS_IDLE; hreadyout_s[1] = 1'b0; hresp_s[1] = 1'b1;
        smp();
        chk("se1_hready", 32'(HREADY), 32'd0);
        chk("se1_hresp",  32'(HRESP), 32'd1);
        chk("se1_irq",    32'(ERR_IRQ), 32'd0);
        cyc(); hreadyout_s[1] = 1'b1;
        smp();
        chk("se2_hready", 32'(HREADY), 32'd1);
        chk("se2_hresp",  32'(HRESP), 32'd1);
        chk("se2_irq",    32'(ERR_IRQ), 32'd0);
        cyc(); hresp_s[1] = 1'b0;
        smp();
        chk("se_after_irq",   32'(ERR_IRQ), 32'd0);
        chk("se_after_cause", 32'(ERR_CAUSE), 32'd2);
        chk("se_after_hresp", 32'(HRESP), 32'd0);

        // Reset in the middle of a long wait abandons the transfer
        cyc();
        HADDR = 32'h1FC0_0080; HTRANS = HTRANS_NONSEQ;
        smp();
        cyc(); HTRANS = HTRANS_IDLE; HADDR = 32'h0; hreadyout_s[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            smp();
            chk($sformatf("rw_wait%0d", i), 32'(HREADY), 32'd0);
        end
        cyc(); HRESET = 1'b1;
        smp();
        chk("rw_during_hready", 32'(HREADY), 32'd1);
        chk("rw_during_hresp",  32'(HRESP), 32'd0);
        cyc(); HRESET = 1'b0;
        smp();
        chk("rw_after_hready", 32'(HREADY), 32'd1);
        chk("rw_after_hresp",  32'(HRESP), 32'd0);
        chk("rw_after_hrdata", HRDATA, 32'h0);
        chk("rw_after_cause",  32'(ERR_CAUSE), 32'd0);
        chk("rw_after_irq",    32'(ERR_IRQ), 32'd0);
        cyc(); hreadyout_s[0] = 1'b1;
        smp();
        chk("rw_settle_irq", 32'(ERR_IRQ), 32'd0);

        // Normal traffic resumes after reset
        cyc();
        HADDR = 32'h0000_0100; HTRANS = HTRANS_NONSEQ;
        hrdata_s[63:32] = 32'h0BAD_C0DE;
        push_exp(32'h0BAD_C0DE, 1'b0);
        smp();
        chk("pr_hsel", 32'(HSEL_S), 32'd2);
        cyc(); HTRANS = HTRANS_IDLE; HADDR = 32'h0;
        smp();
        chk("pr_hrdata", HRDATA, 32'h0BAD_C0DE);
        cyc(); smp();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
